// File: rtl/regfile_ctrl_fsm.sv
// Sequencing FSM for the 8x16 register file and ALU datapath.
// Latches one instruction per start pulse and steps the datapath controls one state per cycle.
module regfile_ctrl_fsm #(
    parameter int INSTR_W = 16,
    parameter int RN_W    = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               s,
    input  logic [INSTR_W-1:0] instr,
    output logic               w,
    output logic               illegal,
    output logic [RN_W-1:0]    readnum,
    output logic [RN_W-1:0]    writenum,
    output logic               write,
    output logic               loada,
    output logic               loadb,
    output logic               loadc,
    output logic               loads,
    output logic               asel,
    output logic [1:0]         vsel,
    output logic [1:0]         ALUop,
    output logic [1:0]         shift,
    output logic [INSTR_W-1:0] sximm8
);

    // state  | meaning
    // WAIT   | idle, w=1, samples s
    // GETA   | read Rn into A
    // GETB   | read Rm into B
    // ALU    | load C from ALU result
    // STATUS | load status flags (CMP)
    // WR_REG | write C back to Rd
    // WR_IMM | write sximm8 to Rn
    // BAD    | unsupported opcode/op, pulse illegal
    typedef enum logic [2:0] {
        S_WAIT, S_GETA, S_GETB, S_ALU, S_STATUS, S_WR_REG, S_WR_IMM, S_BAD
    } state_t;

    state_t             state, state_next;
    logic [INSTR_W-1:0] ir;

    function automatic state_t first_state(input logic [INSTR_W-1:0] i);
        logic [2:0] opc;
        logic [1:0] op;
        opc = i[15:13];
        op  = i[12:11];
        if (opc == 3'b110 && op == 2'b10)      first_state = S_WR_IMM;
        else if (opc == 3'b110 && op == 2'b00) first_state = S_GETB;
        else if (opc == 3'b101 && op == 2'b11) first_state = S_GETB;
        else if (opc == 3'b101)                first_state = S_GETA;
        else                                   first_state = S_BAD;
    endfunction

    logic ir_cmp, ir_unary;
    assign ir_cmp   = (ir[15:13] == 3'b101) && (ir[12:11] == 2'b01);
    assign ir_unary = ((ir[15:13] == 3'b110) && (ir[12:11] == 2'b00)) ||
                      ((ir[15:13] == 3'b101) && (ir[12:11] == 2'b11));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == S_WAIT && s)
                ir <= instr;
        end
    end

    always_comb begin
        state_next = state;
        w          = 1'b0;
        illegal    = 1'b0;
        readnum    = '0;
        writenum   = '0;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        vsel       = 2'b00;
        unique case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s)
                    state_next = first_state(instr);
            end
            S_GETA: begin
                readnum    = ir[10:8];
                loada      = 1'b1;
                state_next = S_GETB;
            end
            S_GETB: begin
                readnum    = ir[2:0];
                loadb      = 1'b1;
                state_next = ir_cmp ? S_STATUS : S_ALU;
            end
            S_ALU: begin
                loadc      = 1'b1;
                asel       = ir_unary;
                state_next = S_WR_REG;
            end
            S_STATUS: begin
                loads      = 1'b1;
                state_next = S_WAIT;
            end
            S_WR_REG: begin
                write      = 1'b1;
                writenum   = ir[7:5];
                state_next = S_WAIT;
            end
            S_WR_IMM: begin
                write      = 1'b1;
                writenum   = ir[10:8];
                vsel       = 2'b10;
                state_next = S_WAIT;
            end
            S_BAD: begin
                illegal    = 1'b1;
                state_next = S_WAIT;
            end
            default: state_next = S_WAIT;
        endcase
    end

    assign ALUop  = ir[12:11];
    assign shift  = ir[4:3];
    assign sximm8 = {{(INSTR_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_regfile_ctrl_fsm.sv
// Self-checking bench for regfile_ctrl_fsm: directed scenarios plus random instructions
// checked cycle by cycle against a per-instruction micro-op list model.
module tb_regfile_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s;
    logic [15:0] instr;
    logic        w, illegal, write, loada, loadb, loadc, loads, asel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, ALUop, shift;
    logic [15:0] sximm8;

    int passed = 0;
    int total  = 0;

    logic [14:0] exp_q[$];

    regfile_ctrl_fsm dut (
        .clk(clk), .reset_n(reset_n), .s(s), .instr(instr),
        .w(w), .illegal(illegal), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .vsel(vsel), .ALUop(ALUop),
        .shift(shift), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [14:0] obs_vec();
        return {readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel, illegal};
    endfunction

    function automatic logic [14:0] mk(input logic [2:0] rn, input logic [2:0] wn,
                                       input logic wr, input logic la, input logic lb,
                                       input logic lc, input logic ls, input logic as,
                                       input logic [1:0] vs, input logic ill);
        return {rn, wn, wr, la, lb, lc, ls, as, vs, ill};
    endfunction

    // Expected control vector for each cycle w is low, derived from the instruction class.
    function automatic void build(input logic [15:0] i);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op;
        opc = i[15:13]; op = i[12:11];
        rn = i[10:8]; rd = i[7:5]; rm = i[2:0];
        exp_q.delete();
        if (opc == 3'd6 && op == 2'd2) begin
            exp_q.push_back(mk(0, rn, 1, 0, 0, 0, 0, 0, 2'b10, 0));
        end else if ((opc == 3'd6 && op == 2'd0) || (opc == 3'd5 && op == 2'd3)) begin
            exp_q.push_back(mk(rm, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0));
            exp_q.push_back(mk(0, rd, 1, 0, 0, 0, 0, 0, 2'b00, 0));
        end else if (opc == 3'd5 && (op == 2'd0 || op == 2'd2)) begin
            exp_q.push_back(mk(rn, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
            exp_q.push_back(mk(rm, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0));
            exp_q.push_back(mk(0, rd, 1, 0, 0, 0, 0, 0, 2'b00, 0));
        end else if (opc == 3'd5 && op == 2'd1) begin
            exp_q.push_back(mk(rn, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0));
            exp_q.push_back(mk(rm, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0));
        end else begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present instr with s=1 for one edge; returns #1 after the latching edge.
    task automatic start(input logic [15:0] i, input bit hold_s);
        instr = i;
        s     = 1'b1;
        tick();
        if (!hold_s) s = 1'b0;
    endtask

    // Checks every busy cycle of latched instruction li, then the return to WAIT.
    task automatic check_seq(input logic [15:0] li, input bit swap, input logic [15:0] new_i);
        logic [15:0] sx;
        sx = {{8{li[7]}}, li[7:0]};
        build(li);
        for (int k = 0; k < exp_q.size(); k++) begin
            chk($sformatf("ctl[%0d] %h", k, li), {17'd0, obs_vec()}, {17'd0, exp_q[k]});
            chk($sformatf("w[%0d] %h", k, li), {31'd0, w}, 32'd0);
            chk($sformatf("hold[%0d] %h", k, li), {12'd0, ALUop, shift, sximm8},
                {12'd0, li[12:11], li[4:3], sx});
            if (swap && k == 0) instr = new_i;
            tick();
        end
        chk($sformatf("w_ret %h", li), {31'd0, w}, 32'd1);
        chk($sformatf("idle_ctl %h", li), {17'd0, obs_vec()}, 32'd0);
        chk($sformatf("hold_ret %h", li), {12'd0, ALUop, shift, sximm8},
            {12'd0, li[12:11], li[4:3], sx});
    endtask

    initial begin
        logic [15:0] r, r2;
        reset_n = 1'b0;
        s       = 1'b0;
        instr   = 16'h0000;

        // reset state
        tick(); tick();
        chk("rst_w", {31'd0, w}, 32'd1);
        chk("rst_ctl", {17'd0, obs_vec()}, 32'd0);
        chk("rst_ir", {12'd0, ALUop, shift, sximm8}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // MOV R3,#-5
        start(16'hD3FB, 1'b0);
        check_seq(16'hD3FB, 1'b0, 16'h0);
        tick();

        // ADD R2,R1,R0 LSL1
        start(16'hA148, 1'b0);
        check_seq(16'hA148, 1'b0, 16'h0);

        // CMP R1,R0
        start(16'hA900, 1'b0);
        check_seq(16'hA900, 1'b0, 16'h0);

        // s held high, instr changed mid-ADD: next instr latched only from WAIT
        start(16'hA148, 1'b1);
        check_seq(16'hA148, 1'b1, 16'hC3A5);
        tick();
        s = 1'b0;
        check_seq(16'hC3A5, 1'b0, 16'h0);

        // reset during ALU state of ADD
        start(16'hA148, 1'b0);
        tick(); tick();
        chk("pre_abort_loadc", {31'd0, loadc}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_w", {31'd0, w}, 32'd1);
        chk("abort_ctl", {17'd0, obs_vec()}, 32'd0);
        tick();
        chk("abort_hold_write", {31'd0, write}, 32'd0);
        chk("abort_ir", {16'd0, sximm8}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        start(16'h0000, 1'b0);
        check_seq(16'h0000, 1'b0, 16'h0);

        // random instructions, biased toward supported opcodes
        for (int n = 0; n < 60; n++) begin
            r = 16'($urandom);
            case ($urandom_range(0, 3))
                0: r[15:13] = 3'b110;
                1, 2: r[15:13] = 3'b101;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                r2 = 16'($urandom);
                start(r, 1'b1);
                check_seq(r, 1'b1, r2);
                tick();
                s = 1'b0;
                check_seq(r2, 1'b0, 16'h0);
            end else begin
                start(r, 1'b0);
                check_seq(r, 1'b0, 16'h0);
                if ($urandom_range(0, 1) == 1) tick();
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
